// File: rtl/d_branch_scoreboard_if.sv
// d_branch_scoreboard_if: D-stage hazard/branch bundle between the decode stage and the scoreboard
interface d_branch_scoreboard_if #(parameter int STALL_CNT_W = 16);
    logic [4:0]             d_rs;
    logic [4:0]             d_rt;
    logic [1:0]             d_tuse_rs;
    logic [1:0]             d_tuse_rt;
    logic                   d_is_branch;
    logic                   d_br_ne;
    logic [4:0]             d_wr_addr;
    logic [1:0]             d_tnew;
    logic [31:0]            rf_rd1;
    logic [31:0]            rf_rd2;
    logic [31:0]            e_fwd_data;
    logic [31:0]            m_fwd_data;
    logic [31:0]            w_fwd_data;
    logic                   stall;
    logic [1:0]             fwd_sel_rs;
    logic [1:0]             fwd_sel_rt;
    logic [31:0]            cmp_a;
    logic [31:0]            cmp_b;
    logic                   br_taken;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_branch, d_br_ne, d_wr_addr, d_tnew,
               rf_rd1, rf_rd2, e_fwd_data, m_fwd_data, w_fwd_data,
        input  stall, fwd_sel_rs, fwd_sel_rt, cmp_a, cmp_b, br_taken, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_branch, d_br_ne, d_wr_addr, d_tnew,
               rf_rd1, rf_rd2, e_fwd_data, m_fwd_data, w_fwd_data,
        output stall, fwd_sel_rs, fwd_sel_rt, cmp_a, cmp_b, br_taken, stall_cnt
    );
endinterface

// File: rtl/d_branch_scoreboard.sv
// d_branch_scoreboard: E/M/W write scoreboard deciding D-stage stall/forward and resolving beq/bne
module d_branch_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input logic                   clk,
    input logic                   reset,
    d_branch_scoreboard_if.slave  bus
);
    // slot index 0 = E, 1 = M, 2 = W
    logic [2:0][4:0]        dst;
    logic [2:0][1:0]        tnew;
    logic                   stall_rs;
    logic                   stall_rt;
    logic [1:0]             sel_rs;
    logic [1:0]             sel_rt;
    logic [STALL_CNT_W-1:0] cnt;

    // walk W -> E so the youngest matching stage overrides older ones; returns {stall, fwd_sel}
    function automatic logic [2:0] resolve(input logic [4:0] src, input logic [1:0] tuse);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 2; i >= 0; i--)
            if (src != 5'd0 && tuse != 2'd3 && dst[i] == src)
                r = {tnew[i] > tuse, tnew[i] == 2'd0 ? 2'(i + 1) : 2'd0};
        return r;
    endfunction

    // per-operand hazard resolution against the nearest in-flight writer
    always_comb begin
        {stall_rs, sel_rs} = resolve(bus.d_rs, bus.d_tuse_rs);
        {stall_rt, sel_rt} = resolve(bus.d_rt, bus.d_tuse_rt);
    end

    assign bus.stall      = stall_rs | stall_rt;
    assign bus.fwd_sel_rs = sel_rs;
    assign bus.fwd_sel_rt = sel_rt;
    assign bus.cmp_a      = sel_rs == 2'd0 ? bus.rf_rd1 : sel_rs == 2'd1 ? bus.e_fwd_data :
                            sel_rs == 2'd2 ? bus.m_fwd_data : bus.w_fwd_data;
    assign bus.cmp_b      = sel_rt == 2'd0 ? bus.rf_rd2 : sel_rt == 2'd1 ? bus.e_fwd_data :
                            sel_rt == 2'd2 ? bus.m_fwd_data : bus.w_fwd_data;
    assign bus.br_taken   = bus.d_is_branch & ~bus.stall & ((bus.cmp_a == bus.cmp_b) ^ bus.d_br_ne);
    assign bus.stall_cnt  = cnt;

    // advance the pipeline shadow; a stalled D instruction enters E as a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst  <= '0;
            tnew <= '0;
        end else begin
            dst[2]  <= dst[1];
            tnew[2] <= tnew[1] == 2'd0 ? 2'd0 : tnew[1] - 2'd1;
            dst[1]  <= dst[0];
            tnew[1] <= tnew[0] == 2'd0 ? 2'd0 : tnew[0] - 2'd1;
            dst[0]  <= bus.stall ? 5'd0 : bus.d_wr_addr;
            tnew[0] <= bus.stall ? 2'd0 : bus.d_tnew;
        end
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (bus.stall && !(&cnt))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_d_branch_scoreboard.sv
// tb_d_branch_scoreboard: queue-based scoreboard bench with a cycle-timestamp reference model
module tb_d_branch_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    d_branch_scoreboard_if #(.STALL_CNT_W(16)) bus();
    d_branch_scoreboard #(.STALL_CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        stall;
        logic [1:0]  sr;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] b;
        logic        bt;
        logic [15:0] cnt;
    } exp_t;

    // an in-flight write: entered E at cycle c0, result ready at cycle ready
    typedef struct {
        logic [4:0] dst;
        int         ready;
        int         c0;
    } ent_t;

    exp_t        q[$];
    ent_t        infl[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] cnt = 16'd0;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, ex, $time);
        end
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r, e, m, w);
        return s == 2'd0 ? r : s == 2'd1 ? e : s == 2'd2 ? m : w;
    endfunction

    // nearest writer = most recent entry still within E..W; remaining latency from its ready cycle
    function automatic void look(input logic [4:0] src, input logic [1:0] tuse,
                                 output logic st, output logic [1:0] sel);
        int best;
        int rem;
        best = -1;
        st = 1'b0;
        sel = 2'd0;
        foreach (infl[k])
            if (src != 5'd0 && tuse != 2'd3 && infl[k].dst == src &&
                cyc - infl[k].c0 >= 0 && cyc - infl[k].c0 <= 2 &&
                (best < 0 || infl[k].c0 > infl[best].c0))
                best = k;
        if (best >= 0) begin
            rem = infl[best].ready - cyc;
            if (rem < 0) rem = 0;
            st = rem > int'(tuse);
            sel = rem == 0 ? 2'(cyc - infl[best].c0 + 1) : 2'd0;
        end
    endfunction

    function automatic void model_reset();
        infl.delete();
        cnt = 16'd0;
    endfunction

    task automatic drive(input logic [4:0] rs, rt, input logic [1:0] ur, ut, input logic br, ne,
                         input logic [4:0] wr, input logic [1:0] tn,
                         input logic [31:0] r1, r2, ed, md, wd);
        bus.d_rs = rs; bus.d_rt = rt; bus.d_tuse_rs = ur; bus.d_tuse_rt = ut;
        bus.d_is_branch = br; bus.d_br_ne = ne; bus.d_wr_addr = wr; bus.d_tnew = tn;
        bus.rf_rd1 = r1; bus.rf_rd2 = r2;
        bus.e_fwd_data = ed; bus.m_fwd_data = md; bus.w_fwd_data = wd;
    endtask

    // one D-stage cycle: drive, predict, enqueue, then advance the model across the clock edge
    task automatic step(input logic [4:0] rs, rt, input logic [1:0] ur, ut, input logic br, ne,
                        input logic [4:0] wr, input logic [1:0] tn,
                        input logic [31:0] r1, r2, ed, md, wd, output logic st);
        logic s1, s2;
        logic [1:0] sa, sb;
        exp_t e;
        drive(rs, rt, ur, ut, br, ne, wr, tn, r1, r2, ed, md, wd);
        look(rs, ur, s1, sa);
        look(rt, ut, s2, sb);
        e.stall = s1 | s2;
        e.sr = sa;
        e.st = sb;
        e.a = pick(sa, r1, ed, md, wd);
        e.b = pick(sb, r2, ed, md, wd);
        e.bt = br & ~e.stall & ((e.a == e.b) != ne);
        e.cnt = cnt;
        q.push_back(e);
        st = e.stall;
        if (e.stall) begin
            if (cnt != 16'hFFFF) cnt++;
        end else if (wr != 5'd0)
            infl.push_back('{dst: wr, ready: cyc + 1 + int'(tn), c0: cyc + 1});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // monitor: every cycle with a pending prediction, compare the DUT's combinational outputs
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", 32'(bus.stall), 32'(e.stall));
            chk("fwd_sel_rs", 32'(bus.fwd_sel_rs), 32'(e.sr));
            chk("fwd_sel_rt", 32'(bus.fwd_sel_rt), 32'(e.st));
            chk("cmp_a", bus.cmp_a, e.a);
            chk("cmp_b", bus.cmp_b, e.b);
            chk("br_taken", 32'(bus.br_taken), 32'(e.bt));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
        end
    end

    initial begin
        logic st;
        int n;
        logic [31:0] r1;
        drive(5'd3, 5'd4, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'hA5, 32'h5A, 32'h1, 32'h2, 32'h3);
        #3;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_sel_rs", 32'(bus.fwd_sel_rs), 32'd0);
        chk("rst_sel_rt", 32'(bus.fwd_sel_rt), 32'd0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_cmp_a", bus.cmp_a, 32'hA5);
        chk("rst_cmp_b", bus.cmp_b, 32'h5A);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        step(5'd1, 5'd2, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0, st);

        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd8, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, st);
        n = 0;
        do begin
            step(5'd8, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'h1, 32'h0, 32'hE, 32'hD, 32'h77, st);
            n++;
        end while (st && n < 6);
        chk("lw_stall_cnt", 32'(bus.stall_cnt), 32'd2);

        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd9, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, st);
        n = 0;
        do begin
            step(5'd9, 5'd9, 2'd0, 2'd0, 1'b1, 1'b1, 5'd0, 2'd0, 32'h1, 32'h2, 32'h11, 32'h11, 32'h3, st);
            n++;
        end while (st && n < 6);
        chk("add_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd31, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, st);
        step(5'd31, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h3004, 32'h1, 32'h2, st);

        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, st);
        step(5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'h4, 32'h4, 32'h9, 32'h9, 32'h9, st);

        for (int i = 0; i < 400; i++) begin
            r1 = $urandom;
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                 r1, $urandom_range(0, 1) ? r1 : $urandom,
                 $urandom_range(0, 1) ? r1 : $urandom, $urandom_range(0, 1) ? r1 : $urandom,
                 $urandom, st);
        end

        for (int i = 0; i < 3; i++)
            step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, st);
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd8, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, st);
        drive(5'd8, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0);
        #1;
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_stall", 32'(bus.stall), 32'd0);
        chk("async_rst_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("async_rst_sel", 32'(bus.fwd_sel_rs), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(5'd8, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 2'd0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, st);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
